// File: rtl/equation_sched_if.sv
// Bundle between the equation scheduler and its environment: requester
// handshakes, datapath operands/result and the response stream.
// Optional: EQ_SCHED_PERF_EN adds the perf_issue/perf_stall counters.
interface equation_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                   en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*8-1:0]   req_a;
  logic [NUM_REQ*8-1:0]   req_b;
  logic [NUM_REQ*8-1:0]   req_c;
  logic [NUM_REQ-1:0]     req_ready;
  logic [7:0]             eq_a;
  logic [7:0]             eq_b;
  logic [7:0]             eq_c;
  logic [15:0]            eq_e;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [15:0]            rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;
`ifdef EQ_SCHED_PERF_EN
  logic [31:0]            perf_issue;
  logic [31:0]            perf_stall;
`endif

  // Scheduler side
  modport master (
    input  en, req_valid, req_a, req_b, req_c, eq_e, rsp_ready,
    output req_ready, eq_a, eq_b, eq_c, rsp_valid, rsp_data, rsp_id, busy
`ifdef EQ_SCHED_PERF_EN
    , output perf_issue, perf_stall
`endif
  );

  // Environment side: requesters, datapath and response consumer
  modport slave (
    output en, req_valid, req_a, req_b, req_c, eq_e, rsp_ready,
    input  req_ready, eq_a, eq_b, eq_c, rsp_valid, rsp_data, rsp_id, busy
`ifdef EQ_SCHED_PERF_EN
    , input perf_issue, perf_stall
`endif
  );
endinterface

// File: rtl/equation_sched.sv
// Round-robin scheduler sharing one non-stallable pipelined equation
// datapath among NUM_REQ requesters. Issued requests are tagged with their
// requester ID, the tag is delayed by PIPE_LAT, and the result is captured
// into a response FIFO. Credits bound in-flight + stored results to
// FIFO_DEPTH so the FIFO can never overflow.
// Optional: EQ_SCHED_PERF_EN adds saturating issue/stall counters.
module equation_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  equation_sched_if.master io_sched
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_busy;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [PIPE_LAT-1:0] r_tag_v;
  logic [PIPE_LAT-1:0] w_tag_v_next;
  logic [ID_W-1:0]     r_tag_id [PIPE_LAT];
  logic [15:0]         r_fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]     r_fifo_id [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic [CNT_W-1:0]    r_credits;
  logic                w_grant_found;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_idx;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;

  function automatic logic [PTR_W-1:0] fifo_ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [ID_W-1:0] rr_ptr_inc(input logic [ID_W-1:0] p);
    return (32'(p) == NUM_REQ - 1) ? '0 : p + ID_W'(1);
  endfunction

  // Round-robin search: first valid requester at or after the pointer
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_grant_found && io_sched.req_valid[w_idx]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_idx;
      end
    end
  end

  // Issue only while running, enabled and holding a registered credit
  assign w_issue = (r_state == ST_RUN) && io_sched.en && (r_credits != '0) && w_grant_found;
  assign w_push  = r_tag_v[PIPE_LAT-1];
  assign w_pop   = (r_count != '0) && io_sched.rsp_ready;

  // Grant and operand mux toward the datapath; zero when nothing issues
  always_comb begin
    io_sched.req_ready = '0;
    io_sched.eq_a      = '0;
    io_sched.eq_b      = '0;
    io_sched.eq_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_issue && (w_grant_id == ID_W'(i))) begin
        io_sched.req_ready[i] = 1'b1;
        io_sched.eq_a         = io_sched.req_a[8*i +: 8];
        io_sched.eq_b         = io_sched.req_b[8*i +: 8];
        io_sched.eq_c         = io_sched.req_c[8*i +: 8];
      end
    end
  end

  // Next tag-valid vector and FIFO occupancy, shared by FSM and registers
  always_comb begin
    w_tag_v_next    = '0;
    w_tag_v_next[0] = w_issue;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      w_tag_v_next[i] = r_tag_v[i-1];
    end
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // FSM next state; DRAIN leaves as soon as nothing will remain next cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (io_sched.en) w_state_next = ST_RUN;
      ST_RUN:   if (!io_sched.en) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (io_sched.en) begin
          w_state_next = ST_RUN;
        end else if ((w_tag_v_next == '0) && (w_count_next == '0)) begin
          w_state_next = ST_IDLE;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register and registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  // Round-robin pointer and credit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_credits <= CNT_W'(FIFO_DEPTH);
    end else begin
      if (w_issue) r_rr_ptr <= rr_ptr_inc(w_grant_id);
      r_credits <= r_credits - CNT_W'(w_issue) + CNT_W'(w_pop);
    end
  end

  // Tag delay line matching the datapath latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v     <= w_tag_v_next;
      r_tag_id[0] <= w_grant_id;
      for (int unsigned i = 1; i < PIPE_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  // Response FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_id[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= io_sched.eq_e;
        r_fifo_id[r_wr_ptr]   <= r_tag_id[PIPE_LAT-1];
        r_wr_ptr              <= fifo_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= fifo_ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  assign io_sched.rsp_valid = (r_count != '0);
  assign io_sched.rsp_data  = io_sched.rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign io_sched.rsp_id    = io_sched.rsp_valid ? r_fifo_id[r_rd_ptr] : '0;
  assign io_sched.busy      = r_busy;

`ifdef EQ_SCHED_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (r_state == ST_RUN) && (|io_sched.req_valid) && (r_credits == '0);

  // Saturating issue and credit-stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue && (r_perf_issue != '1)) r_perf_issue <= r_perf_issue + 32'd1;
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign io_sched.perf_issue = r_perf_issue;
  assign io_sched.perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_equation_sched.sv
// Directed bench for equation_sched with a behavioural 3-stage datapath
// (E = 5A+5B-4C+3D, D fixed at 768) driving eq_e.
module tb_equation_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam logic [15:0] EXP_E [4] = '{16'd2434, 16'd2530, 16'd2626, 16'd2722};
  localparam logic [7:0]  A_TAB [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  localparam int          D_CONST = 768;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n_overflow;

  logic [15:0] p1, p2, p3;

  equation_sched_if #(.NUM_REQ(NUM_REQ)) sif ();

  equation_sched #(
    .NUM_REQ    (NUM_REQ),
    .PIPE_LAT   (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_sched (sif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-stallable datapath: three register stages, combinational output
  initial begin
    p1 = '0;
    p2 = '0;
    p3 = '0;
  end
  always @(posedge clk) begin
    p1 <= 16'(5 * int'(sif.eq_a) + 5 * int'(sif.eq_b) - 4 * int'(sif.eq_c) + 3 * D_CONST);
    p2 <= p1;
    p3 <= p2;
  end
  assign sif.eq_e = p3;

  // Watch for a FIFO push while full
  always @(negedge clk) begin
    if (!rst && dut.w_push && (int'(dut.r_count) == 4)) n_overflow++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    sif.en        = 1'b0;
    sif.req_valid = '0;
    sif.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_id(input logic [NUM_REQ-1:0] oh);
    int id;
    id = -1;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) id = i;
    return id;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sif.en = 1'b1;
    sif.req_valid = '1;
    sif.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b expected 0000", sif.req_ready); end
    checks++; if (sif.eq_a !== 8'd0) begin failures++; $display("FAIL rst_eq_a: got %0d expected 0", sif.eq_a); end
    checks++; if (sif.eq_b !== 8'd0) begin failures++; $display("FAIL rst_eq_b: got %0d expected 0", sif.eq_b); end
    checks++; if (sif.eq_c !== 8'd0) begin failures++; $display("FAIL rst_eq_c: got %0d expected 0", sif.eq_c); end
    checks++; if (sif.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", sif.rsp_valid); end
    checks++; if (sif.rsp_data !== 16'd0) begin failures++; $display("FAIL rst_rsp_data: got %0d expected 0", sif.rsp_data); end
    checks++; if (sif.rsp_id !== 2'd0) begin failures++; $display("FAIL rst_rsp_id: got %0d expected 0", sif.rsp_id); end
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", sif.busy); end
`ifdef EQ_SCHED_PERF_EN
    checks++; if (sif.perf_issue !== 32'd0) begin failures++; $display("FAIL rst_perf_issue: got %0d expected 0", sif.perf_issue); end
    checks++; if (sif.perf_stall !== 32'd0) begin failures++; $display("FAIL rst_perf_stall: got %0d expected 0", sif.perf_stall); end
`endif
    step();
    sif.en = 1'b0;
    sif.req_valid = '0;
    sif.rsp_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_req();
    do_reset();
    sif.rsp_ready = 1'b1;
    sif.en = 1'b1;
    step();
    sif.req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (sif.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", sif.req_ready); end
    checks++; if (sif.eq_a !== 8'd10) begin failures++; $display("FAIL single_eq_a: got %0d expected 10", sif.eq_a); end
    checks++; if (sif.eq_b !== 8'd20) begin failures++; $display("FAIL single_eq_b: got %0d expected 20", sif.eq_b); end
    checks++; if (sif.eq_c !== 8'd5) begin failures++; $display("FAIL single_eq_c: got %0d expected 5", sif.eq_c); end
    checks++; if (sif.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", sif.busy); end
    step();
    sif.req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (sif.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid t+%0d: got %b expected 0", k, sif.rsp_valid); end
      step();
    end
    @(negedge clk);
    checks++; if (sif.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %b expected 1", sif.rsp_valid); end
    checks++; if (sif.rsp_data !== 16'h0982) begin failures++; $display("FAIL single_rsp_data: got %0d expected 2434", sif.rsp_data); end
    checks++; if (sif.rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id: got %0d expected 0", sif.rsp_id); end
    step();
    @(negedge clk);
    checks++; if (sif.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_after_pop: got %b expected 0", sif.rsp_valid); end
    step();
  endtask

  task automatic test_round_robin();
    int gq[$];
    int iq[$];
    logic [15:0] dq[$];
    int gid;
    do_reset();
    sif.en = 1'b1;
    sif.rsp_ready = 1'b1;
    step();
    sif.req_valid = '1;
    for (int cyc = 0; cyc < 60 && iq.size() < 8; cyc++) begin
      @(negedge clk);
      if (sif.req_ready !== 4'b0000) begin
        gid = onehot_id(sif.req_ready);
        checks++; if ($countones(sif.req_ready) != 1) begin failures++; $display("FAIL rr_onehot: got %b expected one bit", sif.req_ready); end
        if (gid >= 0) begin
          checks++; if (sif.eq_a !== A_TAB[gid]) begin failures++; $display("FAIL rr_eq_a: got %0d expected %0d", sif.eq_a, A_TAB[gid]); end
        end
        gq.push_back(gid);
      end
      if (sif.rsp_valid === 1'b1) begin
        dq.push_back(sif.rsp_data);
        iq.push_back(int'(sif.rsp_id));
      end
      step();
      if (gq.size() >= 8) sif.req_valid = '0;
    end
    checks++; if (gq.size() != 8) begin failures++; $display("FAIL rr_grant_count: got %0d expected 8", gq.size()); end
    checks++; if (iq.size() != 8) begin failures++; $display("FAIL rr_rsp_count: got %0d expected 8", iq.size()); end
    for (int k = 0; k < gq.size() && k < 8; k++) begin
      checks++; if (gq[k] != k % 4) begin failures++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, gq[k], k % 4); end
    end
    for (int k = 0; k < iq.size() && k < 8; k++) begin
      checks++; if (iq[k] != k % 4) begin failures++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", k, iq[k], k % 4); end
      checks++; if (dq[k] !== EXP_E[k % 4]) begin failures++; $display("FAIL rr_rsp_data[%0d]: got %0d expected %0d", k, dq[k], EXP_E[k % 4]); end
    end
  endtask

  task automatic test_backpressure();
    int ng;
    int iq[$];
    logic [15:0] dq[$];
    ng = 0;
    do_reset();
    sif.en = 1'b1;
    sif.rsp_ready = 1'b0;
    step();
    sif.req_valid = '1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (sif.req_ready !== 4'b0000) ng++;
      step();
    end
    @(negedge clk);
    checks++; if (ng != 4) begin failures++; $display("FAIL bp_issue_count: got %0d expected 4", ng); end
    checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_blocked: got %b expected 0000", sif.req_ready); end
    checks++; if (sif.rsp_data !== 16'd2434) begin failures++; $display("FAIL bp_hold_data: got %0d expected 2434", sif.rsp_data); end
    checks++; if (sif.rsp_id !== 2'd0) begin failures++; $display("FAIL bp_hold_id: got %0d expected 0", sif.rsp_id); end
    step();
    sif.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && iq.size() < 8; cyc++) begin
      @(negedge clk);
      if (sif.req_ready !== 4'b0000) ng++;
      if (sif.rsp_valid === 1'b1) begin
        dq.push_back(sif.rsp_data);
        iq.push_back(int'(sif.rsp_id));
      end
      step();
      if (ng >= 8) sif.req_valid = '0;
    end
    checks++; if (ng != 8) begin failures++; $display("FAIL bp_total_issues: got %0d expected 8", ng); end
    checks++; if (iq.size() != 8) begin failures++; $display("FAIL bp_rsp_count: got %0d expected 8", iq.size()); end
    for (int k = 0; k < iq.size() && k < 8; k++) begin
      checks++; if (iq[k] != k % 4) begin failures++; $display("FAIL bp_rsp_id[%0d]: got %0d expected %0d", k, iq[k], k % 4); end
      checks++; if (dq[k] !== EXP_E[k % 4]) begin failures++; $display("FAIL bp_rsp_data[%0d]: got %0d expected %0d", k, dq[k], EXP_E[k % 4]); end
    end
    repeat (3) step();
    @(negedge clk);
    checks++; if (sif.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_no_extra: got %b expected 0", sif.rsp_valid); end
    step();
  endtask

  task automatic test_drain();
    int ng;
    int extra;
    int busy_bad;
    ng = 0;
    extra = 0;
    busy_bad = 0;
    do_reset();
    sif.en = 1'b1;
    sif.rsp_ready = 1'b0;
    step();
    sif.req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sif.req_ready !== 4'b0000) ng++;
      step();
    end
    sif.en = 1'b0;
    sif.req_valid = '0;
    @(negedge clk);
    if (sif.req_ready !== 4'b0000) extra++;
    step();
    sif.req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sif.req_ready !== 4'b0000) extra++;
      if (sif.busy !== 1'b1) busy_bad++;
      step();
    end
    @(negedge clk);
    checks++; if (ng != 3) begin failures++; $display("FAIL drain_issued: got %0d expected 3", ng); end
    checks++; if (extra != 0) begin failures++; $display("FAIL drain_new_grants: got %0d expected 0", extra); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL drain_busy_low: got %0d cycles expected 0", busy_bad); end
    checks++; if (sif.rsp_valid !== 1'b1) begin failures++; $display("FAIL drain_rsp_valid: got %b expected 1", sif.rsp_valid); end
    step();
    sif.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (sif.rsp_valid !== 1'b1 || sif.rsp_id !== 2'(k)) begin failures++; $display("FAIL drain_pop[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", k, sif.rsp_valid, sif.rsp_id, k); end
      checks++; if (sif.busy !== 1'b1) begin failures++; $display("FAIL drain_pop_busy[%0d]: got %b expected 1", k, sif.busy); end
      step();
    end
    @(negedge clk);
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL drain_idle_busy: got %b expected 0", sif.busy); end
    checks++; if (sif.rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_idle_valid: got %b expected 0", sif.rsp_valid); end
    checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL drain_idle_grant: got %b expected 0000", sif.req_ready); end
    step();
    sif.req_valid = '0;
  endtask

  task automatic test_async_reset();
    int late;
    int ng;
    late = 0;
    ng = 0;
    do_reset();
    sif.en = 1'b1;
    sif.rsp_ready = 1'b0;
    step();
    sif.req_valid = '1;
    repeat (4) step();
    sif.req_valid = '0;
    step();
    #2;
    checks++; if (sif.rsp_valid !== 1'b1 || sif.rsp_data !== 16'd2434) begin failures++; $display("FAIL areset_pre: got valid=%b data=%0d expected valid=1 data=2434", sif.rsp_valid, sif.rsp_data); end
    rst = 1'b1;
    #1;
    checks++; if (sif.rsp_valid !== 1'b0) begin failures++; $display("FAIL areset_rsp_valid: got %b expected 0", sif.rsp_valid); end
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL areset_busy: got %b expected 0", sif.busy); end
    checks++; if (sif.rsp_data !== 16'd0) begin failures++; $display("FAIL areset_rsp_data: got %0d expected 0", sif.rsp_data); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sif.en = 1'b1;
    sif.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sif.rsp_valid === 1'b1) late++;
      step();
    end
    checks++; if (late != 0) begin failures++; $display("FAIL areset_stale_rsp: got %0d expected 0", late); end
    sif.rsp_ready = 1'b0;
    sif.req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sif.req_ready !== 4'b0000) ng++;
      step();
    end
    checks++; if (ng != 4) begin failures++; $display("FAIL areset_credits: got %0d expected 4", ng); end
    sif.req_valid = '0;
  endtask

`ifdef EQ_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    sif.en = 1'b1;
    sif.rsp_ready = 1'b0;
    step();
    sif.req_valid = '1;
    repeat (7) step();
    sif.req_valid = '0;
    sif.rsp_ready = 1'b1;
    repeat (4) step();
    sif.rsp_ready = 1'b0;
    sif.req_valid = 4'b0001;
    repeat (2) step();
    sif.req_valid = '0;
    @(negedge clk);
    checks++; if (sif.perf_issue !== 32'd6) begin failures++; $display("FAIL perf_issue: got %0d expected 6", sif.perf_issue); end
    checks++; if (sif.perf_stall !== 32'd3) begin failures++; $display("FAIL perf_stall: got %0d expected 3", sif.perf_stall); end
    step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    n_overflow = 0;
    rst = 1'b1;
    sif.en = 1'b0;
    sif.req_valid = '0;
    sif.rsp_ready = 1'b0;
    sif.req_a = {8'd40, 8'd30, 8'd20, 8'd10};
    sif.req_b = {8'd50, 8'd40, 8'd30, 8'd20};
    sif.req_c = {8'd8, 8'd7, 8'd6, 8'd5};
    test_reset();
    test_single_req();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_async_reset();
`ifdef EQ_SCHED_PERF_EN
    test_perf();
`endif
    checks++; if (n_overflow != 0) begin failures++; $display("FAIL fifo_overflow: got %0d pushes while full expected 0", n_overflow); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
